// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem read at a time, with a one-entry holding
// register towards ID. Branch redirects from IE take priority in every state.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_b_sel,
  input  logic [31:0] i_b_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcp,
  output logic        o_inst_valid,
  input  logic        i_inst_ready
);

  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] ResetPc = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2,
    StHold = 2'd3
  } state_e;

  state_e      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [31:0] r_pcp;
  logic        r_inst_valid;

  logic [31:0] w_target;
  logic [31:0] w_fetch_pc_inc;

  assign w_target       = i_b_target & 32'hFFFF_FFFC;
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StReq;
      r_fetch_pc   <= ResetPc;
      r_inst       <= Nop;
      r_pc         <= ResetPc;
      r_pcp        <= ResetPc + 32'd4;
      r_inst_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StReq: begin
          if (i_b_sel) begin
            r_fetch_pc <= w_target;
            // A grant in the redirect cycle was for the stale address; its data must be eaten.
            r_state    <= i_imem_gnt ? StDrop : StReq;
          end else if (i_imem_gnt) begin
            r_state <= StWait;
          end
        end
        StWait: begin
          if (i_b_sel) begin
            r_fetch_pc <= w_target;
            r_state    <= i_imem_rvalid ? StReq : StDrop;
          end else if (i_imem_rvalid) begin
            r_inst       <= i_imem_rdata;
            r_pc         <= r_fetch_pc;
            r_pcp        <= w_fetch_pc_inc;
            r_inst_valid <= 1'b1;
            r_fetch_pc   <= w_fetch_pc_inc;
            r_state      <= StHold;
          end
        end
        StDrop: begin
          if (i_b_sel) begin
            r_fetch_pc <= w_target;
          end
          // The pending response is consumed even if a redirect lands in the same cycle,
          // otherwise DROP would wait for a response that never arrives.
          if (i_imem_rvalid) begin
            r_state <= StReq;
          end
        end
        StHold: begin
          if (i_b_sel) begin
            r_fetch_pc   <= w_target;
            r_inst_valid <= 1'b0;
            r_state      <= StReq;
          end else if (i_inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= StReq;
          end
        end
        default: r_state <= StReq;
      endcase
    end
  end

  // Gated by reset so the request is low while held in reset and high right after release.
  assign o_imem_req   = (r_state == StReq) && i_rst_n;
  assign o_imem_addr  = r_fetch_pc;
  assign o_inst       = r_inst;
  assign o_pc         = r_pc;
  assign o_pcp        = r_pcp;
  assign o_inst_valid = r_inst_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: fetch, stall, redirects in each state, PC wrap and async reset.
module tb_if_fetch;

  logic        clk;
  logic        rst_n;
  logic        b_sel;
  logic [31:0] b_target;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_ready;

  logic        imem_req,   imem_req1;
  logic [31:0] imem_addr,  imem_addr1;
  logic [31:0] inst,       inst1;
  logic [31:0] pc,         pc1;
  logic [31:0] pcp,        pcp1;
  logic        inst_valid, inst_valid1;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_b_sel       (b_sel),
    .i_b_target    (b_target),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_inst        (inst),
    .o_pc          (pc),
    .o_pcp         (pcp),
    .o_inst_valid  (inst_valid),
    .i_inst_ready  (inst_ready)
  );

  // Second instance exercises the 2^32 wrap from the top word of the address space.
  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_b_sel       (b_sel),
    .i_b_target    (b_target),
    .o_imem_req    (imem_req1),
    .o_imem_addr   (imem_addr1),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_inst        (inst1),
    .o_pc          (pc1),
    .o_pcp         (pcp1),
    .o_inst_valid  (inst_valid1),
    .i_inst_ready  (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},   32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst"},  inst,                32'h0000_0013);
    chk({tag, "_pc"},    pc,                  32'h0000_0000);
    chk({tag, "_pcp"},   pcp,                 32'h0000_0004);
    chk({tag, "_addr"},  imem_addr,           32'h0000_0000);
  endtask

  initial begin
    rst_n       = 1'b1;
    b_sel       = 1'b0;
    b_target    = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    inst_ready  = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("rst");
    chk("rst_wrap_pc",  pc1,  32'hFFFF_FFFC);
    chk("rst_wrap_pcp", pcp1, 32'h0000_0000);

    // Basic fetch at address 0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    tick();
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("f0_valid", {31'd0, inst_valid}, 32'd1);
    chk("f0_inst",  inst,      32'h0050_0093);
    chk("f0_pc",    pc,        32'h0000_0000);
    chk("f0_pcp",   pcp,       32'h0000_0004);
    chk("f0_addr",  imem_addr, 32'h0000_0004);
    chk("wrap_pc",   pc1,        32'hFFFF_FFFC);
    chk("wrap_pcp",  pcp1,       32'h0000_0000);
    chk("wrap_addr", imem_addr1, 32'h0000_0000);

    // Stall in HOLD for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_inst",  inst,                 32'h0050_0093);
      chk("hold_pc",    pc,                   32'h0000_0000);
      chk("hold_pcp",   pcp,                  32'h0000_0004);
      chk("hold_req",   {31'd0, imem_req},   32'd0);
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("acc_valid", {31'd0, inst_valid}, 32'd0);
    chk("acc_req",   {31'd0, imem_req},   32'd1);
    chk("acc_addr",  imem_addr,           32'h0000_0004);

    // Redirect in WAIT before data, stale data arrives in DROP
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    b_sel    = 1'b1;
    b_target = 32'h0000_0012;
    tick();
    b_sel = 1'b0;
    chk("drop_req",  {31'd0, imem_req}, 32'd0);
    chk("drop_addr", imem_addr,         32'h0000_0010);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_inst",  inst,                32'h0050_0093);
    chk("drop_req2",  {31'd0, imem_req},   32'd1);
    chk("drop_addr2", imem_addr,           32'h0000_0010);

    // Fetch from the redirect target
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    chk("f1_valid", {31'd0, inst_valid}, 32'd1);
    chk("f1_inst",  inst, 32'h00A0_0113);
    chk("f1_pc",    pc,   32'h0000_0010);
    chk("f1_pcp",   pcp,  32'h0000_0014);

    // Redirect in HOLD with ID stalled
    b_sel    = 1'b1;
    b_target = 32'h0000_0014;
    tick();
    b_sel = 1'b0;
    chk("hbr_valid", {31'd0, inst_valid}, 32'd0);
    chk("hbr_req",   {31'd0, imem_req},   32'd1);
    chk("hbr_addr",  imem_addr,           32'h0000_0014);

    // Redirect in REQ without grant: new address appears, still requesting
    b_sel    = 1'b1;
    b_target = 32'h0000_0103;
    tick();
    b_sel = 1'b0;
    chk("rbr_req",  {31'd0, imem_req}, 32'd1);
    chk("rbr_addr", imem_addr,         32'h0000_0100);

    // Redirect in REQ together with grant: stale response is dropped
    b_sel    = 1'b1;
    b_target = 32'h0000_0200;
    imem_gnt = 1'b1;
    tick();
    b_sel    = 1'b0;
    imem_gnt = 1'b0;
    chk("rgb_req",  {31'd0, imem_req}, 32'd0);
    chk("rgb_addr", imem_addr,         32'h0000_0200);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    chk("rgb_valid", {31'd0, inst_valid}, 32'd0);
    chk("rgb_req2",  {31'd0, imem_req},   32'd1);

    // Redirect in WAIT coinciding with rvalid: data discarded, straight back to REQ
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    b_sel       = 1'b1;
    b_target    = 32'h0000_0300;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    b_sel       = 1'b0;
    imem_rvalid = 1'b0;
    chk("wbr_valid", {31'd0, inst_valid}, 32'd0);
    chk("wbr_req",   {31'd0, imem_req},   32'd1);
    chk("wbr_addr",  imem_addr,           32'h0000_0300);
    chk("wbr_inst",  inst,                32'h00A0_0113);

    // Asynchronous reset mid-cycle while in WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("arst");
    @(negedge clk);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_0000;
    tick();
    imem_rvalid = 1'b0;
    chk("post_req",   {31'd0, imem_req},   32'd1);
    chk("post_addr",  imem_addr,           32'h0000_0000);
    chk("post_valid", {31'd0, inst_valid}, 32'd0);
    chk("post_inst",  inst,                32'h0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
